ascon_msg_sequencer: RTL and testbench

- Synthesizable sequencer sitting between an upstream valid/ready block stream and the ASCON128 `top_level` core.
- Issues `start`, then a runtime-selected number of associated-data (AD) and plaintext (PT) blocks as single-cycle `data_valid` pulses, with configurable inter-block gaps.
- Buffers each cipher block for a downstream valid/ready consumer and captures the final tag.
- Generalises the fixed 1-AD/4-PT, fixed-timing stimulus into a parametrised, handshake-driven block.

---
 rtl/ascon_msg_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_ascon_msg_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_msg_sequencer.sv
// ascon_msg_sequencer
//   Drives an ASCON128 core from an upstream valid/ready block stream. It
//   raises start, waits for the core's init permutation, then feeds the
//   associated-data blocks followed by the plaintext blocks as single-cycle
//   data_valid pulses. Consecutive pulses are at least BLOCK_GAP cycles apart.
//   Cipher blocks from the core are held in a one-entry buffer for a
//   downstream valid/ready consumer. The tag is captured when the core
//   signals end.
//
//   Optional build macro: ASCON_SEQ_WATCHDOG_EN. When it is defined, a
//   watchdog aborts a stalled message and raises error_o.
//
// Ports
//   clock_i, reset_i      clock, synchronous active-high reset
//   go_i                  start one message (sampled in IDLE only)
//   ad_len_i, pt_len_i    AD / PT block counts, latched on go_i
//   in_data_i/valid/ready upstream padded blocks
//   start_o, data_o, data_valid_o           to the core
//   cipher_i, cipher_valid_i, tag_i, end_i  from the core
//   out_data_o/valid/ready                  buffered cipher blocks downstream
//   tag_o                 tag captured on end_i
//   done_o                one-cycle pulse when a message completes
//   busy_o                high whenever the sequencer is not idle
//   overflow_o            sticky; a cipher block was dropped because the buffer was full
//   error_o               sticky watchdog timeout (0 without the macro)
module ascon_msg_sequencer #(
  parameter int DATA_W         = 64,
  parameter int LEN_W          = 4,
  parameter int INIT_WAIT      = 18,
  parameter int BLOCK_GAP      = 11,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              go_i,
  input  logic [LEN_W-1:0]  ad_len_i,
  input  logic [LEN_W-1:0]  pt_len_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              start_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic [DATA_W-1:0] cipher_i,
  input  logic              cipher_valid_i,
  input  logic [127:0]      tag_i,
  input  logic              end_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [127:0]      tag_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              error_o
);

  localparam int MAX_A    = (INIT_WAIT > BLOCK_GAP) ? INIT_WAIT : BLOCK_GAP;
  localparam int MAX_WAIT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  // A wait state lasts N-1 cycles. The following SEND cycle supplies the
  // remaining cycle, so a pulse comes exactly N cycles after the previous
  // event when upstream data is already waiting.
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLOCK_GAP - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_AD_SEND, S_AD_GAP, S_PT_SEND, S_PT_GAP, S_FINAL
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LEN_W-1:0]    ad_cnt_q;
  logic [LEN_W-1:0]    pt_cnt_q;
  logic                start_q;
  logic [DATA_W-1:0]   data_q;
  logic                data_valid_q;
  logic [127:0]        tag_q;
  logic                done_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                overflow_q;
  logic                in_xfer;

  // A PT block is accepted only while the output buffer is empty. This
  // keeps at most one cipher block in flight when the consumer stalls.
  assign in_ready_o = (state_q == S_AD_SEND) ||
                      ((state_q == S_PT_SEND) && !out_valid_q);
  assign in_xfer    = in_valid_i && in_ready_o;

`ifdef ASCON_SEQ_WATCHDOG_EN
  logic [CNT_W-1:0] wd_q;
  logic             error_q;
  logic             wd_activity;
  assign wd_activity = in_xfer || data_valid_q || end_i;
  assign error_o     = error_q;
`else
  assign error_o     = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ad_cnt_q     <= '0;
      pt_cnt_q     <= '0;
      start_q      <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      tag_q        <= '0;
      done_q       <= 1'b0;
`ifdef ASCON_SEQ_WATCHDOG_EN
      wd_q         <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            ad_cnt_q <= ad_len_i;
            pt_cnt_q <= pt_len_i;
            cnt_q    <= '0;
            start_q  <= 1'b1;
            state_q  <= S_INIT;
          end
        end
        S_INIT: begin
          if (cnt_q == INIT_LAST) begin
            cnt_q <= '0;
            if (ad_cnt_q != '0) begin
              state_q <= S_AD_SEND;
            end else if (pt_cnt_q != '0) begin
              state_q <= S_PT_SEND;
            end else begin
              start_q <= 1'b0;
              state_q <= S_FINAL;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_AD_SEND, S_PT_SEND: begin
          // start is held only through the first SEND cycle after INIT.
          start_q <= 1'b0;
          if (in_xfer) begin
            data_q       <= in_data_i;
            data_valid_q <= 1'b1;
            cnt_q        <= '0;
            if (state_q == S_AD_SEND) begin
              if (ad_cnt_q != '0) ad_cnt_q <= ad_cnt_q - 1'b1;
              state_q <= S_AD_GAP;
            end else begin
              if (pt_cnt_q != '0) pt_cnt_q <= pt_cnt_q - 1'b1;
              state_q <= S_PT_GAP;
            end
          end
        end
        S_AD_GAP, S_PT_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if ((state_q == S_AD_GAP) && (ad_cnt_q != '0)) begin
              state_q <= S_AD_SEND;
            end else if (pt_cnt_q != '0) begin
              state_q <= S_PT_SEND;
            end else begin
              state_q <= S_FINAL;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FINAL: begin
          if (end_i) begin
            tag_q   <= tag_i;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef ASCON_SEQ_WATCHDOG_EN
      // These assignments come after the case statement, so a timeout
      // overrides whatever the FSM would otherwise do in that cycle.
      if (state_q == S_IDLE || wd_activity) begin
        wd_q <= '0;
      end else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        wd_q    <= '0;
        error_q <= 1'b1;
        start_q <= 1'b0;
        state_q <= S_IDLE;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
`endif
    end
  end

  // One-entry cipher buffer. It runs independently of the FSM, so it
  // accepts a block whenever it is empty or being drained in the same cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (cipher_valid_i && (!out_valid_q || out_ready_i)) begin
        out_data_q  <= cipher_i;
        out_valid_q <= 1'b1;
      end else begin
        if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
        if (cipher_valid_i) overflow_q <= 1'b1;
      end
    end
  end

  assign start_o      = start_q;
  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign tag_o        = tag_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != S_IDLE);
  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ascon_msg_sequencer.sv
// Directed testbench for ascon_msg_sequencer. The bench stands in for both
// the upstream source and the ASCON core. The cipher and tag values it
// returns are fixed constants.
module tb_ascon_msg_sequencer;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          go_i = 1'b0;
  logic [3:0]    ad_len_i = '0;
  logic [3:0]    pt_len_i = '0;
  logic [63:0]   in_data_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          start_o;
  logic [63:0]   data_o;
  logic          data_valid_o;
  logic [63:0]   cipher_i = '0;
  logic          cipher_valid_i = 1'b0;
  logic [127:0]  tag_i = '0;
  logic          end_i = 1'b0;
  logic [63:0]   out_data_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [127:0]  tag_o;
  logic          done_o;
  logic          busy_o;
  logic          overflow_o;
  logic          error_o;

  ascon_msg_sequencer dut (
    .clock_i(clk), .reset_i(reset_i), .go_i(go_i),
    .ad_len_i(ad_len_i), .pt_len_i(pt_len_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .start_o(start_o), .data_o(data_o), .data_valid_o(data_valid_o),
    .cipher_i(cipher_i), .cipher_valid_i(cipher_valid_i), .tag_i(tag_i), .end_i(end_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .tag_o(tag_o), .done_o(done_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int dv_total = 0;
  int done_total = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid_o) dv_total <= dv_total + 1;
    if (done_o) done_total <= done_total + 1;
  end

  logic [63:0] blk [5] = '{64'h3230323380000000, 64'h436F6E636576657A,
                           64'h204153434F4E2065, 64'h6E2053797374656D,
                           64'h566572696C6F6780};
  logic [63:0] ciph [4] = '{64'hC0FFEE0011223344, 64'h0123456789ABCDEF,
                            64'hDEADBEEFCAFEF00D, 64'hA5A5A5A55A5A5A5A};
  logic [127:0] tag1 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  logic [127:0] tag2 = 128'h11112222333344445555666677778888;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers one upstream block, waits for its data_valid pulse, and for a PT
  // block plays the core by returning one cipher word shortly afterwards.
  task automatic send_block(input logic [63:0] b, input logic is_pt,
                            input logic [63:0] c, output int pcyc);
    logic found;
    found = 1'b0;
    in_data_i = b;
    in_valid_i = 1'b1;
    for (int k = 0; k < 100 && !found; k++) begin
      tick;
      if (data_valid_o) found = 1'b1;
    end
    check("dv_seen", 128'(found), 128'd1);
    pcyc = cyc;
    check("data_o", 128'(data_o), 128'(b));
    tick;
    check("dv_one_cycle", 128'(data_valid_o), 128'd0);
    if (is_pt) begin
      tick;
      cipher_i = c;
      cipher_valid_i = 1'b1;
      tick;
      cipher_valid_i = 1'b0;
      check("out_valid_load", 128'(out_valid_o), 128'd1);
      check("out_data", 128'(out_data_o), 128'(c));
      tick;
      check("out_valid_drain", 128'(out_valid_o), 128'(!out_ready_i));
    end
  endtask

  task automatic finish_msg(input logic [127:0] t);
    repeat (12) tick;
    end_i = 1'b1;
    tag_i = t;
    tick;
    end_i = 1'b0;
    check("done_pulse", 128'(done_o), 128'd1);
    check("tag_o", tag_o, t);
    check("busy_after_done", 128'(busy_o), 128'd0);
    tick;
    check("done_width", 128'(done_o), 128'd0);
  endtask

  initial begin
    int c0, pc, prev, dv0, dn0;
    logic found;

    // Reset state
    tick; tick;
    check("rst_start", 128'(start_o), 128'd0);
    check("rst_dv", 128'(data_valid_o), 128'd0);
    check("rst_in_ready", 128'(in_ready_o), 128'd0);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_out_valid", 128'(out_valid_o), 128'd0);
    check("rst_tag", tag_o, 128'd0);
    check("rst_ovf_err", {overflow_o, error_o, done_o}, 128'd0);
    reset_i = 1'b0;
    tick;

    // Full message: 1 AD block, 4 PT blocks, consumer always ready
    $display("step 1: full message ad=1 pt=4");
    dv0 = dv_total; dn0 = done_total;
    ad_len_i = 4'd1; pt_len_i = 4'd4; out_ready_i = 1'b1;
    in_data_i = blk[0]; in_valid_i = 1'b1;
    go_i = 1'b1;
    tick;
    go_i = 1'b0;
    c0 = cyc;
    check("go_start", 128'(start_o), 128'd1);
    check("go_busy", 128'(busy_o), 128'd1);
    check("init_in_ready", 128'(in_ready_o), 128'd0);
    prev = c0;
    for (int i = 0; i < 5; i++) begin
      send_block(blk[i], (i > 0), ciph[(i > 0) ? i - 1 : 0], pc);
      if (i == 0) begin
        check("first_latency", 128'(pc - c0), 128'd18);
        check("start_dropped", 128'(start_o), 128'd0);
        // go while busy with different lengths must not change the message
        go_i = 1'b1; ad_len_i = 4'd3; pt_len_i = 4'd0;
        tick;
        go_i = 1'b0;
      end else begin
        check("block_gap", 128'(pc - prev), 128'd11);
      end
      $display("  block %0d sent at cycle %0d", i, pc - c0);
      prev = pc;
    end
    finish_msg(tag1);
    check("msg1_pulses", 128'(dv_total - dv0), 128'd5);
    check("msg1_done_count", 128'(done_total - dn0), 128'd1);

    // Zero lengths
    $display("step 2: zero lengths");
    dv0 = dv_total;
    ad_len_i = 4'd0; pt_len_i = 4'd0;
    go_i = 1'b1;
    tick;
    go_i = 1'b0;
    repeat (30) tick;
    check("zero_no_pulses", 128'(dv_total - dv0), 128'd0);
    check("zero_final_busy", 128'(busy_o), 128'd1);
    check("zero_final_start", 128'(start_o), 128'd0);
    finish_msg(tag2);

    // Downstream backpressure
    $display("step 3: backpressure");
    ad_len_i = 4'd0; pt_len_i = 4'd4; out_ready_i = 1'b0;
    go_i = 1'b1;
    tick;
    go_i = 1'b0;
    send_block(blk[1], 1'b1, ciph[0], pc);
    dv0 = dv_total;
    repeat (40) tick;
    check("bp_in_ready", 128'(in_ready_o), 128'd0);
    check("bp_no_pulse", 128'(dv_total - dv0), 128'd0);
    check("bp_no_overflow", 128'(overflow_o), 128'd0);
    check("bp_hold_data", 128'(out_data_o), 128'(ciph[0]));
    out_ready_i = 1'b1;
    tick;
    check("bp_drained", 128'(out_valid_o), 128'd0);
    for (int i = 2; i < 5; i++) begin
      send_block(blk[i], 1'b1, ciph[i - 1], pc);
      $display("  block %0d sent after release", i);
    end
    check("bp_pulses", 128'(dv_total - dv0), 128'd3);
    finish_msg(tag1);

    // Overflow: two cipher words with no drain
    $display("step 4: overflow");
    out_ready_i = 1'b0;
    cipher_i = ciph[2]; cipher_valid_i = 1'b1;
    tick;
    cipher_i = ciph[3];
    tick;
    cipher_valid_i = 1'b0;
    check("ovf_set", 128'(overflow_o), 128'd1);
    check("ovf_keep_first", 128'(out_data_o), 128'(ciph[2]));
    check("ovf_valid", 128'(out_valid_o), 128'd1);
    tick;
    check("ovf_sticky", 128'(overflow_o), 128'd1);

    // Reset during PT_GAP aborts the message
    $display("step 5: reset mid-message");
    out_ready_i = 1'b1;
    tick;
    ad_len_i = 4'd0; pt_len_i = 4'd2;
    go_i = 1'b1;
    tick;
    go_i = 1'b0;
    send_block(blk[1], 1'b0, 64'd0, pc);
    dn0 = done_total;
    reset_i = 1'b1;
    tick;
    reset_i = 1'b0;
    check("rstm_busy", 128'(busy_o), 128'd0);
    check("rstm_flags", {start_o, data_valid_o, in_ready_o, out_valid_o, done_o, overflow_o}, 128'd0);
    check("rstm_tag", tag_o, 128'd0);
    check("rstm_data", {data_o, out_data_o}, 128'd0);
    dv0 = dv_total;
    repeat (30) tick;
    check("rstm_no_pulses", 128'(dv_total - dv0), 128'd0);
    check("rstm_no_done", 128'(done_total - dn0), 128'd0);
    check("rstm_idle", 128'(busy_o), 128'd0);

`ifdef ASCON_SEQ_WATCHDOG_EN
    // Watchdog: end_i never arrives
    $display("step 6: watchdog");
    dn0 = done_total;
    ad_len_i = 4'd0; pt_len_i = 4'd0;
    go_i = 1'b1;
    tick;
    go_i = 1'b0;
    c0 = cyc;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick;
      if (error_o) found = 1'b1;
    end
    check("wd_error", 128'(found), 128'd1);
    check("wd_latency", 128'(cyc - c0), 128'd255);
    check("wd_idle", 128'(busy_o), 128'd0);
    check("wd_no_done", 128'(done_total - dn0), 128'd0);
`else
    found = 1'b0;
    check("no_wd_error", 128'(error_o), 128'(found));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
